// File: rtl/kpn_pkg.sv
// Shared token format and default FIFO sizing for the KPN node library.
package kpn_pkg;

  localparam int TOKEN_WIDTH     = 16;
  localparam int INT_BITS        = 12;
  localparam int FRAC_BITS       = 4;
  localparam int FIFO_ADDR_WIDTH = 3;

  // Q12.4 fixed-point token exchanged between processing nodes.
  typedef struct packed {
    logic signed [INT_BITS-1:0] int_part;
    logic        [FRAC_BITS-1:0] frac_part;
  } token_t;

endpackage

// File: rtl/kpn_fifo_mem.sv
// DEPTH x DATA_WIDTH storage with one synchronous write and one synchronous read port.
module kpn_fifo_mem
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH = TOKEN_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read samples the pre-edge contents, so a read and a write to the same
  // slot in one cycle returns the old token.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/kpn_channel_fifo.sv
// Bounded KPN channel: pointer/count bookkeeping, back-pressure flags and
// sticky access-error flags around a dual-port token store.
module kpn_channel_fifo
  import kpn_pkg::*;
#(
  parameter int DATA_WIDTH = TOKEN_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  has_data_p1;
  logic [DATA_WIDTH-1:0] mem_rdata_p1;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  kpn_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (mem_rdata_p1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      data_valid  <= 1'b0;
      has_data_p1 <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      data_valid <= rd_ok;
      if (rd_ok)        has_data_p1 <= 1'b1;
      if (wr && !wr_ok) overflow    <= 1'b1;
      if (rd && empty)  underflow   <= 1'b1;
    end
  end

  // ---- read stage p1: storage holds its last read; mask it to zero until
  // the first read after reset so reset clears data_out immediately.
  assign data_out = has_data_p1 ? mem_rdata_p1 : '0;

endmodule

// File: tb/tb_kpn_channel_fifo.sv
// Self-checking bench for kpn_channel_fifo: table vectors, directed corner
// sequences and a token scoreboard against a queue model.
module tb_kpn_channel_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic        rd;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        full, empty, data_valid, overflow, underflow;
  logic [3:0]  count;

  int tests  = 0;
  int failed = 0;

  logic [15:0] model_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] m_dout;
  bit          m_dv, m_ovf, m_unf;

  kpn_channel_fifo #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .data_in    (data_in),
    .full       (full),
    .rd         (rd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    bit          rd;
    logic [15:0] din;
    logic [3:0]  exp_count;
    bit          exp_dv;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    m_dout = '0;
    m_dv   = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // Drive one cycle, advance the model on pre-edge state, compare after the edge.
  task automatic step(input bit w, input bit r, input logic [15:0] d);
    bit rok, wok, was_empty;
    logic [15:0] exp_tok;
    wr = w; rd = r; data_in = d;
    was_empty = (model_q.size() == 0);
    rok = r && !was_empty;
    wok = w && (model_q.size() < 8 || rok);
    @(posedge clk); #1;
    if (rok) begin
      m_dout = model_q.pop_front();
      exp_q.push_back(m_dout);
    end
    if (wok) model_q.push_back(d);
    if (w && !wok) m_ovf = 1'b1;
    if (r && was_empty) m_unf = 1'b1;
    m_dv = rok;
    check("count", 32'(count), 32'(model_q.size()));
    check("empty", 32'(empty), 32'(model_q.size() == 0));
    check("full", 32'(full), 32'(model_q.size() == 8));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("data_valid", 32'(data_valid), 32'(m_dv));
    check("data_out_hold", 32'(data_out), 32'(m_dout));
    if (data_valid) begin
      if (exp_q.size() == 0) check("scoreboard_extra_token", 32'(data_out), 32'hDEAD_BEEF);
      else begin
        exp_tok = exp_q.pop_front();
        check("scoreboard_token", 32'(data_out), 32'(exp_tok));
      end
    end
    wr = 1'b0; rd = 1'b0;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any clock.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_flags", {29'd0, data_valid, overflow, underflow}, 32'd0);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h0123, 4'd1, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0456, 4'd2, 1'b0, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0789, 4'd3, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 16'h0000, 4'd2, 1'b1, 16'h0123};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 4'd1, 1'b1, 16'h0456};
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 4'd0, 1'b1, 16'h0789};

    model_reset();
    reset = 1'b1; wr = 1'b0; rd = 1'b1; data_in = '0;

    // Test 1: reset held with rd asserted.
    repeat (2) @(posedge clk);
    #1;
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_count", 32'(count), 32'd0);
    check("t1_data_out", 32'(data_out), 32'd0);
    #2 reset = 1'b0;
    step(1'b0, 1'b1, 16'h0);
    check("t1_underflow", 32'(underflow), 32'd1);

    // Test 2: table-driven write/read sequence.
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("t2_count_%0d", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("t2_dv_%0d", i), 32'(data_valid), 32'(vecs[i].exp_dv));
      if (vecs[i].exp_dv) check($sformatf("t2_dout_%0d", i), 32'(data_out), 32'(vecs[i].exp_dout));
    end
    check("t2_empty_end", 32'(empty), 32'd1);

    // Test 3: fill, drop on full, drain in order.
    pulse_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(16'h0010 * i));
    check("t3_full", 32'(full), 32'd1);
    step(1'b1, 1'b0, 16'h0FFF);
    check("t3_overflow", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 16'h0);
      check("t3_drain", 32'(data_out), 32'(16'h0010 * i));
    end

    // Test 4: simultaneous read and write while full.
    pulse_reset();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 16'(16'h0010 * i));
    step(1'b1, 1'b1, 16'h0AAA);
    check("t4_dout", 32'(data_out), 32'h0010);
    check("t4_count", 32'(count), 32'd8);
    check("t4_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'h0);
    check("t4_last", 32'(data_out), 32'h0AAA);

    // Test 5: simultaneous read and write while empty, no bypass.
    pulse_reset();
    step(1'b1, 1'b1, 16'h0055);
    check("t5_count", 32'(count), 32'd1);
    check("t5_unf", 32'(underflow), 32'd1);
    check("t5_dv", 32'(data_valid), 32'd0);
    step(1'b0, 1'b1, 16'h0);
    check("t5_dout", 32'(data_out), 32'h0055);

    // Test 6: wrap pointers, then reset with tokens stored.
    pulse_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'(16'h0100 + i));
    for (int i = 5; i < 20; i++) step(1'b1, 1'b1, 16'(16'h0100 + i));
    check("t6_count5", 32'(count), 32'd5);
    pulse_reset();
    step(1'b1, 1'b0, 16'h0B01);
    step(1'b1, 1'b0, 16'h0B02);
    step(1'b0, 1'b1, 16'h0);
    check("t6_new1", 32'(data_out), 32'h0B01);
    step(1'b0, 1'b1, 16'h0);
    check("t6_new2", 32'(data_out), 32'h0B02);
    step(1'b0, 1'b1, 16'h0);
    check("t6_unf", 32'(underflow), 32'd1);

    // Random interleavings of strobes, checked by the model every cycle.
    pulse_reset();
    for (int i = 0; i < 120; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
